// File: rtl/arcade_input_mapper.sv
// Player-input front end: merges PS/2 key events and HPS joysticks into registered
// per-player directions, buttons and starts, with autofire and a timed coin-pulse FSM.
module arcade_input_mapper #(
   parameter int          NPLAYERS     = 2,
   parameter int          NBUTTONS     = 2,
   parameter logic [23:0] COIN_CYCLES  = 24'd1_000_000,
   parameter logic [19:0] AUTOFIRE_DIV = 20'd400_000,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic                         clk_sys,
   input  logic                         reset_n,
   input  logic [10:0]                  ps2_key,
   input  logic [16*NPLAYERS-1:0]       joystick,
   input  logic [NPLAYERS-1:0]          autofire_en,
   output logic [4*NPLAYERS-1:0]        out_dir,
   output logic [NBUTTONS*NPLAYERS-1:0] out_btn,
   output logic [NPLAYERS-1:0]          out_start,
   output logic                         out_coin
);

   // Handshake-free block: every input is sampled on each clk_sys edge, and every
   // output is a register updated on every edge (no valid/ready pairs involved).

   typedef enum logic [1:0] {
      COIN_IDLE     = 2'd0,
      COIN_PULSE    = 2'd1,
      COIN_GAP      = 2'd2,
      COIN_PEND_CHK = 2'd3
   } coin_state_t;

   function automatic logic [8:0] btn_code(input int k);
      case (k)
         0:       btn_code = 9'h014;
         1:       btn_code = 9'h029;
         2:       btn_code = 9'h011;
         default: btn_code = 9'h012;
      endcase
   endfunction

   function automatic logic [8:0] start_code(input int p);
      case (p)
         0:       start_code = 9'h005;
         1:       start_code = 9'h006;
         2:       start_code = 9'h004;
         default: start_code = 9'h00C;
      endcase
   endfunction

   logic                         primed;
   logic                         old_tog;
   logic [3:0]                   key_dir;
   logic [NBUTTONS-1:0]          key_btn;
   logic [NPLAYERS-1:0]          key_start;
   logic                         key_coin;

   logic [4*NPLAYERS-1:0]        held_dir;
   logic [NBUTTONS*NPLAYERS-1:0] held_btn;
   logic [NBUTTONS*NPLAYERS-1:0] btn_fire;
   logic [NPLAYERS-1:0]          held_start;
   logic                         coin_any;
   logic                         coin_prev;
   logic                         coin_req;

   logic [19:0]                  af_cnt;
   logic                         af_phase;

   coin_state_t                  coin_state;
   coin_state_t                  coin_state_nxt;
   logic [23:0]                  coin_cnt;
   logic [23:0]                  coin_cnt_nxt;
   logic                         pending;
   logic                         pending_nxt;
   logic                         coin_active_nxt;

   logic                         unused_joy;
   assign unused_joy = ^joystick;

   // Key latches; the first edge after reset only primes old_tog so a stale toggle is not decoded.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         primed    <= 1'b0;
         old_tog   <= 1'b0;
         key_dir   <= '0;
         key_btn   <= '0;
         key_start <= '0;
         key_coin  <= 1'b0;
      end else if (!primed) begin
         primed  <= 1'b1;
         old_tog <= ps2_key[10];
      end else if (ps2_key[10] != old_tog) begin
         old_tog <= ps2_key[10];
         case (ps2_key[7:0])
            8'h75:   key_dir[3] <= ps2_key[9];
            8'h72:   key_dir[2] <= ps2_key[9];
            8'h6B:   key_dir[1] <= ps2_key[9];
            8'h74:   key_dir[0] <= ps2_key[9];
            default: ;
         endcase
         for (int k = 0; k < NBUTTONS; k++) begin
            if (ps2_key[8:0] == btn_code(k)) key_btn[k] <= ps2_key[9];
         end
         for (int p = 0; p < NPLAYERS; p++) begin
            if (ps2_key[8:0] == start_code(p)) key_start[p] <= ps2_key[9];
         end
         if (ps2_key[8:0] == 9'h02E) key_coin <= ps2_key[9];
      end
   end

   always_comb begin
      held_dir   = '0;
      held_btn   = '0;
      held_start = '0;
      coin_any   = key_coin;
      for (int p = 0; p < NPLAYERS; p++) begin
         held_dir[4*p +: 4] = joystick[16*p +: 4];
         for (int k = 0; k < NBUTTONS; k++) begin
            held_btn[NBUTTONS*p+k] = joystick[16*p+4+k];
         end
         held_start[p] = joystick[16*p+4+NBUTTONS] | key_start[p];
         coin_any      = coin_any | held_start[p] | joystick[16*p+5+NBUTTONS];
      end
      held_dir[3:0]          = held_dir[3:0] | key_dir;
      held_btn[NBUTTONS-1:0] = held_btn[NBUTTONS-1:0] | key_btn;
   end

   always_comb begin
      btn_fire = held_btn;
      for (int p = 0; p < NPLAYERS; p++) begin
         if (autofire_en[p]) btn_fire[NBUTTONS*p] = held_btn[NBUTTONS*p] & af_phase;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         af_cnt   <= '0;
         af_phase <= 1'b0;
      end else if (af_cnt == AUTOFIRE_DIV - 20'd1) begin
         af_cnt   <= '0;
         af_phase <= ~af_phase;
      end else begin
         af_cnt <= af_cnt + 20'd1;
      end
   end

   assign coin_req = coin_any & ~coin_prev;

   // Coin FSM: state register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin_state <= COIN_IDLE;
         coin_cnt   <= '0;
         pending    <= 1'b0;
         coin_prev  <= 1'b0;
      end else begin
         coin_state <= coin_state_nxt;
         coin_cnt   <= coin_cnt_nxt;
         pending    <= pending_nxt;
         coin_prev  <= coin_any;
      end
   end

   // Coin FSM: next state. Only one request can wait; extra ones are dropped.
   always_comb begin
      coin_state_nxt = coin_state;
      coin_cnt_nxt   = coin_cnt;
      pending_nxt    = pending;
      case (coin_state)
         COIN_IDLE: begin
            if (coin_req) begin
               coin_state_nxt = COIN_PULSE;
               coin_cnt_nxt   = '0;
            end
         end
         COIN_PULSE: begin
            if (coin_req) pending_nxt = 1'b1;
            if (coin_cnt == COIN_CYCLES - 24'd1) begin
               coin_state_nxt = COIN_GAP;
               coin_cnt_nxt   = '0;
            end else begin
               coin_cnt_nxt = coin_cnt + 24'd1;
            end
         end
         COIN_GAP: begin
            if (coin_req) pending_nxt = 1'b1;
            if (coin_cnt == COIN_CYCLES - 24'd1) begin
               coin_state_nxt = COIN_PEND_CHK;
               coin_cnt_nxt   = '0;
            end else begin
               coin_cnt_nxt = coin_cnt + 24'd1;
            end
         end
         COIN_PEND_CHK: begin
            if (pending || coin_req) begin
               coin_state_nxt = COIN_PULSE;
               coin_cnt_nxt   = '0;
               pending_nxt    = 1'b0;
            end else begin
               coin_state_nxt = COIN_IDLE;
            end
         end
         default: coin_state_nxt = COIN_IDLE;
      endcase
   end

   // Coin FSM: output decode, registered below together with the other outputs
   always_comb begin
      coin_active_nxt = (coin_state_nxt == COIN_PULSE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         out_dir   <= {4*NPLAYERS{ACTIVE_LOW}};
         out_btn   <= {NBUTTONS*NPLAYERS{ACTIVE_LOW}};
         out_start <= {NPLAYERS{ACTIVE_LOW}};
         out_coin  <= ACTIVE_LOW;
      end else begin
         out_dir   <= held_dir ^ {4*NPLAYERS{ACTIVE_LOW}};
         out_btn   <= btn_fire ^ {NBUTTONS*NPLAYERS{ACTIVE_LOW}};
         out_start <= held_start ^ {NPLAYERS{ACTIVE_LOW}};
         out_coin  <= coin_active_nxt ^ ACTIVE_LOW;
      end
   end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
Parametrised player-input front end for the arcade cores. It merges PS/2 keyboard events and HPS joysticks into registered per-player directions, action buttons and starts. It adds three things the per-core inline decoders lacked: a timed coin-pulse FSM with a one-deep pending queue, per-player autofire, and selectable output polarity. It sits between hps_io and the core's button inputs.

Parameters:
NPLAYERS, 2, number of players (1..4)
NBUTTONS, 2, action buttons per player (1..4)
COIN_CYCLES, 24'd1_000_000, coin pulse width and following gap, in clk_sys cycles (must be at least 2)
AUTOFIRE_DIV, 20'd400_000, clk_sys cycles per autofire half-period (must be at least 1)
ACTIVE_LOW, 1, 1 = all button outputs inverted (pressed = 0)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] scancode ([8] = extended)
joystick  in  16*NPLAYERS  player p at [16p+15:16p]; bit 3 up, 2 down, 1 left, 0 right, 4+k button k, 4+NBUTTONS start, 5+NBUTTONS coin
autofire_en  in  NPLAYERS  per-player autofire enable for button 0
out_dir  out  4*NPLAYERS  player p at [4p+3:4p] = {up,down,left,right}
out_btn  out  NBUTTONS*NPLAYERS  player p button k at bit NBUTTONS*p+k
out_start  out  NPLAYERS  start per player
out_coin  out  1  coin pulse

Behaviour:
- Reset, asynchronous: all key latches, counters, FSM state and the primed flag clear. Outputs go to the released level: all 0s if ACTIVE_LOW=0, all 1s if ACTIVE_LOW=1.
- Priming: the first clk_sys edge after reset releases captures ps2_key[10] into old_tog and sets primed. No key event is decoded until primed=1. This suppresses a spurious event at power-up.
- Key event: occurs when primed and ps2_key[10] != old_tog. On that edge the matching latch is loaded with ps2_key[9] and old_tog is updated. Unmapped codes are ignored.
- Keyboard drives player 0 only. Scancode bit 8 is ignored for direction keys only; all other matches require the full 9-bit code.
  - Directions: x75 up, x72 down, x6B left, x74 right.
  - Buttons 0..3: 014 ctrl, 029 space, 011 alt, 012 lshift. A key for button k is ignored when k >= NBUTTONS.
  - Starts: F1 005, F2 006, F3 004, F4 00C, mapped to start 0..3. Starts p >= NPLAYERS are ignored.
  - Coin: 02E (key "5").
- Merge: held[p] = key latch (p=0 only) OR joystick bits.
- Autofire: a free-running counter counts 0..AUTOFIRE_DIV-1, wraps, and toggles phase on each wrap; phase resets to 0. When autofire_en[p]=1, button 0 = held & phase; otherwise button 0 = held.
- Output registers: every output is registered once. Joystick to output latency is 1 cycle. ps2_key toggle to output latency is 2 cycles (latch, then output register).
- Coin request: a rising edge of coin_any = OR over players of (held start | held coin). The edge is detected against the previous-cycle value.
- Coin FSM (counter is 24 bits):
  - IDLE, on request: go to PULSE, cnt=0.
  - PULSE: out_coin active. When cnt=COIN_CYCLES-1, go to GAP, cnt=0.
  - GAP: out_coin inactive. When cnt=COIN_CYCLES-1, go to PEND_CHK.
  - PEND_CHK: if pending=1, clear pending and go to PULSE; else go to IDLE.
  - A request arriving in PULSE, GAP or PEND_CHK sets pending. Further requests while pending=1 are dropped (queue depth is one).
  - A request in the same cycle as the GAP-to-PEND_CHK transition is captured as pending.
- out_coin is asserted exactly COIN_CYCLES cycles per pulse. Consecutive pulses are separated by at least COIN_CYCLES+1 inactive cycles.
- Reset mid-pulse: out_coin releases immediately, the FSM returns to IDLE, and pending is cleared.
- Polarity: applied at the output register, so ACTIVE_LOW changes level only, never timing.

Test Plan:
- Reset with ps2_key[10]=1, release reset, hold ps2_key constant for 10 cycles -> no latch changes; with ACTIVE_LOW=1, out_dir=8'hFF throughout.
- Toggle ps2_key with {pressed=1, code=9'h175} -> out_dir[3] goes to 0 exactly 2 cycles later; toggle again with pressed=0 -> returns to 1 after 2 cycles.
- COIN_CYCLES=4: pulse joystick P1 start for 1 cycle -> out_coin active 4 cycles, then inactive; second pulse during PULSE and third during GAP -> exactly one more coin pulse, starting 5 cycles after the first pulse ends.
- AUTOFIRE_DIV=3, autofire_en=2'b01, hold P0 button 0 -> out_btn[0] toggles every 3 cycles; P1 button 0 held (bit 2, NBUTTONS=2) stays steady.
- Assert reset_n=0 on the 2nd cycle of a coin pulse -> out_coin released asynchronously; after release with no request, out_coin stays inactive.
- NPLAYERS=1: send F2 key -> out_start unchanged and no coin pulse; send key "5" -> one coin pulse.
